regfile_onehot_wr: RTL and testbench

- 8-entry general-purpose register file for the RISC CPU datapath.
- Sits directly downstream of the 3-to-8 destination-register decoder and consumes its one-hot output as per-register write enables.
- Provides two registered read ports (A, B) for the ALU operand stage.
- Flags any malformed one-hot select, i.e. zero bits set or more than one bit set.

---
 rtl/regfile_onehot_wr.sv | 96 +++++++++
 tb/tb_regfile_onehot_wr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_onehot_wr.sv
// 8-entry register file with one-hot write selects, two registered read ports,
// a write acknowledge pulse and a sticky malformed-select error flag.
module regfile_onehot_wr #(
    parameter int unsigned WIDTH   = 8,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_a_addr,
    input  logic [2:0]       rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             wr_ack,
    output logic             sel_err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic             wr_ack_q, wr_ack_d;
    logic             sel_err_q, sel_err_d;

    logic sel_onehot;
    logic wr_accept;
    logic wr_illegal;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    assign sel_onehot = (wr_sel != 8'h00) && ((wr_sel & (wr_sel - 8'd1)) == 8'h00);
    assign wr_accept  = wr_en && sel_onehot;
    assign wr_illegal = wr_en && !sel_onehot;

    // Next register contents; register 0 is never written when hardwired to zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_accept && wr_sel[i] && !(ZERO_R0 && (i == 0))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Reads look at next-state contents, giving write-first bypass for free.
    always_comb begin
        rd_a_d = regs_d[rd_a_addr];
        rd_b_d = regs_d[rd_b_addr];
        if (ZERO_R0 && (rd_a_addr == 3'd0)) begin
            rd_a_d = '0;
        end
        if (ZERO_R0 && (rd_b_addr == 3'd0)) begin
            rd_b_d = '0;
        end
    end

    // Status: ack mirrors acceptance; error is sticky and set beats clear.
    always_comb begin
        wr_ack_d  = wr_accept;
        sel_err_d = sel_err_q;
        if (wr_illegal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_ack_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wr_ack_q  <= wr_ack_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign wr_ack    = wr_ack_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr: a plain-array model checked against two instances
// (ZERO_R0 = 0 and 1) every cycle, plus directed literal expectations.
module tb_regfile_onehot_wr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_sel = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [2:0] rd_a_addr = 3'd0;
    logic [2:0] rd_b_addr = 3'd0;
    logic       err_clr = 1'b0;

    logic [7:0] a0, b0, a1, b1;
    logic       ack0, err0, ack1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_onehot_wr #(.WIDTH(8), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(a0), .rd_b_data(b0),
        .wr_ack(ack0), .sel_err(err0), .err_clr(err_clr)
    );

    regfile_onehot_wr #(.WIDTH(8), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(a1), .rd_b_data(b1),
        .wr_ack(ack1), .sel_err(err1), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, index 0 = ZERO_R0 off, index 1 = ZERO_R0 on.
    logic [7:0] mem [2][8];
    logic [7:0] m_a [2];
    logic [7:0] m_b [2];
    logic       m_ack [2];
    logic       m_err [2];
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        int pc;
        int idx;
        pc  = $countones(wr_sel);
        idx = 0;
        for (int i = 0; i < 8; i++) if (wr_sel[i]) idx = i;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
                m_a[k] = 8'h00; m_b[k] = 8'h00; m_ack[k] = 1'b0; m_err[k] = 1'b0;
            end else begin
                if (wr_en && pc == 1 && !(k == 1 && idx == 0)) mem[k][idx] = wr_data;
                m_ack[k] = wr_en && pc == 1;
                if (wr_en && pc != 1) m_err[k] = 1'b1;
                else if (err_clr) m_err[k] = 1'b0;
                m_a[k] = (k == 1 && rd_a_addr == 0) ? 8'h00 : mem[k][rd_a_addr];
                m_b[k] = (k == 1 && rd_b_addr == 0) ? 8'h00 : mem[k][rd_b_addr];
            end
        end
        if (rst) chk_en = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model rd_a", a0, m_a[0]);
            chk("model rd_b", b0, m_b[0]);
            chk("model ack", {7'd0, ack0}, {7'd0, m_ack[0]});
            chk("model err", {7'd0, err0}, {7'd0, m_err[0]});
            chk("model_z rd_a", a1, m_a[1]);
            chk("model_z rd_b", b1, m_b[1]);
            chk("model_z ack", {7'd0, ack1}, {7'd0, m_ack[1]});
            chk("model_z err", {7'd0, err1}, {7'd0, m_err[1]});
        end
    end

    task automatic cyc(input logic en, input logic [7:0] sel, input logic [7:0] data,
                       input logic [2:0] ra, input logic [2:0] rb, input logic clr);
        wr_en = en; wr_sel = sel; wr_data = data;
        rd_a_addr = ra; rd_b_addr = rb; err_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acks;
        logic [7:0] sel;
        // Reset held two cycles with a concurrent write that must be ignored.
        rst = 1'b1;
        cyc(1'b1, 8'h04, 8'hAA, 3'd2, 3'd2, 1'b0);
        cyc(1'b1, 8'h04, 8'hAA, 3'd2, 3'd2, 1'b0);
        rst = 1'b0;
        chk("reset rd_a", a0, 8'h00);
        chk("reset rd_b", b0, 8'h00);
        chk("reset ack", {7'd0, ack0}, 8'h00);
        chk("reset err", {7'd0, err0}, 8'h00);
        cyc(1'b0, 8'h00, 8'h00, 3'd2, 3'd2, 1'b0);
        chk("reset reg2", a0, 8'h00);

        // Sweep writes.
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            sel = 8'h01 << i;
            cyc(1'b1, sel, 8'h10 + 8'(i), 3'd0, 3'd0, 1'b0);
            if (ack0) acks++;
        end
        cyc(1'b0, 8'h00, 8'h00, 3'd0, 3'd7, 1'b0);
        chk("sweep ack count", 8'(acks), 8'd8);
        chk("ack drops", {7'd0, ack0}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            chk("sweep rd_a", a0, 8'h10 + 8'(i));
            chk("sweep rd_b", b0, 8'h17 - 8'(i));
        end

        // Write-first bypass on both ports.
        cyc(1'b1, 8'h08, 8'h11, 3'd0, 3'd0, 1'b0);
        cyc(1'b1, 8'h08, 8'h5C, 3'd3, 3'd3, 1'b0);
        chk("bypass rd_a", a0, 8'h5C);
        chk("bypass rd_b", b0, 8'h5C);
        chk("bypass_z rd_a", a1, 8'h5C);

        // Illegal selects.
        cyc(1'b1, 8'h00, 8'hFF, 3'd3, 3'd4, 1'b0);
        chk("illegal0 ack", {7'd0, ack0}, 8'h00);
        chk("illegal0 err", {7'd0, err0}, 8'h01);
        cyc(1'b1, 8'h18, 8'hFF, 3'd3, 3'd4, 1'b0);
        chk("illegal18 ack", {7'd0, ack0}, 8'h00);
        cyc(1'b0, 8'h00, 8'h00, 3'd3, 3'd4, 1'b0);
        chk("illegal err sticky", {7'd0, err0}, 8'h01);
        chk("illegal reg3", a0, 8'h5C);
        chk("illegal reg4", b0, 8'h14);
        cyc(1'b0, 8'h00, 8'h00, 3'd3, 3'd4, 1'b1);
        chk("err clear", {7'd0, err0}, 8'h00);
        cyc(1'b0, 8'h18, 8'hFF, 3'd3, 3'd4, 1'b0);
        chk("disabled illegal err", {7'd0, err0}, 8'h00);
        chk("disabled illegal reg3", a0, 8'h5C);

        // Clear racing writes.
        cyc(1'b1, 8'h00, 8'hFF, 3'd2, 3'd2, 1'b0);
        chk("race setup err", {7'd0, err0}, 8'h01);
        cyc(1'b1, 8'h04, 8'h22, 3'd2, 3'd2, 1'b1);
        chk("clr+legal err", {7'd0, err0}, 8'h00);
        chk("clr+legal ack", {7'd0, ack0}, 8'h01);
        chk("clr+legal rd_a", a0, 8'h22);
        cyc(1'b1, 8'h03, 8'hFF, 3'd2, 3'd2, 1'b1);
        chk("clr+illegal err", {7'd0, err0}, 8'h01);
        chk("clr+illegal ack", {7'd0, ack0}, 8'h00);
        chk("clr+illegal rd_a", a0, 8'h22);

        // Hardwired-zero register 0.
        cyc(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1);
        cyc(1'b1, 8'h01, 8'h7E, 3'd0, 3'd0, 1'b0);
        chk("zr0 rd_a", a1, 8'h00);
        chk("zr0 ack", {7'd0, ack1}, 8'h01);
        chk("zr0 err", {7'd0, err1}, 8'h00);
        chk("r0 rd_a", a0, 8'h7E);
        cyc(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("zr0 reread", b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
